// File: rtl/fwd_operand_mux.sv
// fwd_operand_mux: registered N-to-1 EX-stage operand forwarding mux with stall/flush, select-error flag and saturating forward counter
module fwd_operand_mux #(
  parameter int WIDTH = 32,
  parameter int NSRC = 4,
  parameter int CNTW = 16,
  localparam int SELW = (NSRC > 1) ? $clog2(NSRC) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NSRC*WIDTH-1:0] in_bus,
  input  logic [SELW-1:0]       sel,
  input  logic                  in_valid,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  cnt_clr,
  output logic [WIDTH-1:0]      out,
  output logic                  out_valid,
  output logic                  sel_err,
  output logic [CNTW-1:0]       fwd_count
);
  logic [WIDTH-1:0] w_pick;
  logic             w_err;
  logic             w_load;
  logic             w_fwd;
  logic [WIDTH-1:0] r_out;
  logic             r_valid;
  logic             r_err;
  logic [CNTW-1:0]  r_cnt;
  // Out-of-range selects fall back to source 0
  always_comb begin
    w_pick = in_bus[WIDTH-1:0];
    for (int k = 1; k < NSRC; k++)
      if (sel == SELW'(k)) w_pick = in_bus[k*WIDTH +: WIDTH];
  end
  assign w_err  = {1'b0, sel} >= (SELW+1)'(NSRC);
  assign w_load = !flush && !stall;
  assign w_fwd  = w_load && in_valid && !w_err && (sel != '0);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_out   <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else if (flush) begin
      r_out   <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else if (!stall) begin
      r_out   <= w_pick;
      r_valid <= in_valid;
      r_err   <= in_valid & w_err;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_cnt <= '0;
    else if (cnt_clr) r_cnt <= '0;
    else if (w_fwd && !(&r_cnt)) r_cnt <= r_cnt + CNTW'(1);
  assign out       = r_out;
  assign out_valid = r_valid;
  assign sel_err   = r_err;
  assign fwd_count = r_cnt;
endmodule

// File: tb/tb_fwd_operand_mux.sv
// tb_fwd_operand_mux: directed vector table plus hand sequences for stall, select error, saturation and async reset
module tb_fwd_operand_mux;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic [127:0] a_bus;
  logic [1:0]   a_sel;
  logic         a_v, a_st, a_fl, a_clr;
  logic [31:0]  a_out;
  logic         a_ov, a_err;
  logic [15:0]  a_cnt;
  logic [95:0]  b_bus;
  logic [1:0]   b_sel;
  logic         b_v, b_st, b_fl, b_clr;
  logic [31:0]  b_out;
  logic         b_ov, b_err;
  logic [15:0]  b_cnt;
  logic [127:0] c_bus;
  logic [1:0]   c_sel;
  logic         c_v, c_st, c_fl, c_clr;
  logic [31:0]  c_out;
  logic         c_ov, c_err;
  logic [3:0]   c_cnt;
  fwd_operand_mux u_a (.clk(clk), .rst_n(rst_n), .in_bus(a_bus), .sel(a_sel), .in_valid(a_v),
    .stall(a_st), .flush(a_fl), .cnt_clr(a_clr), .out(a_out), .out_valid(a_ov), .sel_err(a_err), .fwd_count(a_cnt));
  fwd_operand_mux #(.NSRC(3)) u_b (.clk(clk), .rst_n(rst_n), .in_bus(b_bus), .sel(b_sel), .in_valid(b_v),
    .stall(b_st), .flush(b_fl), .cnt_clr(b_clr), .out(b_out), .out_valid(b_ov), .sel_err(b_err), .fwd_count(b_cnt));
  fwd_operand_mux #(.CNTW(4)) u_c (.clk(clk), .rst_n(rst_n), .in_bus(c_bus), .sel(c_sel), .in_valid(c_v),
    .stall(c_st), .flush(c_fl), .cnt_clr(c_clr), .out(c_out), .out_valid(c_ov), .sel_err(c_err), .fwd_count(c_cnt));
  typedef struct {
    logic [1:0]  sel;
    logic        v, st, fl, clr;
    logic [31:0] eo;
    logic        ev, ee;
    logic [15:0] ec;
  } vec_t;
  vec_t tbl [13];
  int n_chk = 0;
  int n_fail = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    tbl[0]  = '{2'd0, 1, 0, 0, 0, 32'h11111111, 1, 0, 16'd0};
    tbl[1]  = '{2'd1, 1, 0, 0, 0, 32'h22222222, 1, 0, 16'd1};
    tbl[2]  = '{2'd2, 1, 0, 0, 0, 32'h33333333, 1, 0, 16'd2};
    tbl[3]  = '{2'd3, 1, 0, 0, 0, 32'h44444444, 1, 0, 16'd3};
    tbl[4]  = '{2'd1, 0, 0, 0, 0, 32'h22222222, 0, 0, 16'd3};
    tbl[5]  = '{2'd2, 1, 0, 0, 0, 32'h33333333, 1, 0, 16'd4};
    tbl[6]  = '{2'd1, 1, 1, 0, 0, 32'h33333333, 1, 0, 16'd4};
    tbl[7]  = '{2'd3, 1, 1, 1, 0, 32'h00000000, 0, 0, 16'd4};
    tbl[8]  = '{2'd1, 1, 0, 0, 1, 32'h22222222, 1, 0, 16'd0};
    tbl[9]  = '{2'd0, 1, 0, 0, 0, 32'h11111111, 1, 0, 16'd0};
    tbl[10] = '{2'd2, 1, 0, 0, 0, 32'h33333333, 1, 0, 16'd1};
    tbl[11] = '{2'd0, 1, 1, 0, 1, 32'h33333333, 1, 0, 16'd0};
    tbl[12] = '{2'd3, 1, 0, 1, 0, 32'h00000000, 0, 0, 16'd0};
    a_bus = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    {a_sel, a_v, a_st, a_fl, a_clr} = '0;
    b_bus = {32'h12345678, 32'h0BADF00D, 32'hDEADBEEF};
    {b_sel, b_v, b_st, b_fl, b_clr} = '0;
    c_bus = {32'h0, 32'h0, 32'hC0C0C0C1, 32'h0};
    {c_sel, c_v, c_st, c_fl, c_clr} = '0;
    step();
    step();
    chk("rst a_out", a_out, 0);
    chk("rst a_valid", 32'(a_ov), 0);
    chk("rst a_err", 32'(a_err), 0);
    chk("rst a_cnt", 32'(a_cnt), 0);
    chk("rst c_cnt", 32'(c_cnt), 0);
    rst_n = 1'b1;
    for (int i = 0; i < 13; i++) begin
      {a_sel, a_v, a_st, a_fl, a_clr} = {tbl[i].sel, tbl[i].v, tbl[i].st, tbl[i].fl, tbl[i].clr};
      step();
      chk($sformatf("vec%0d out", i), a_out, tbl[i].eo);
      chk($sformatf("vec%0d valid", i), 32'(a_ov), 32'(tbl[i].ev));
      chk($sformatf("vec%0d err", i), 32'(a_err), 32'(tbl[i].ee));
      chk($sformatf("vec%0d cnt", i), 32'(a_cnt), 32'(tbl[i].ec));
    end
    {a_sel, a_v, a_st, a_fl, a_clr} = {2'd2, 1'b1, 1'b0, 1'b0, 1'b0};
    step();
    chk("stall pre out", a_out, 32'h33333333);
    chk("stall pre cnt", 32'(a_cnt), 1);
    a_sel = 2'd1;
    a_st = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a_bus = {4{32'h5A5A0000 + 32'(i)}};
      step();
      chk($sformatf("stall%0d out", i), a_out, 32'h33333333);
      chk($sformatf("stall%0d cnt", i), 32'(a_cnt), 1);
    end
    a_bus = {32'h0, 32'h0, 32'hAAAA5555, 32'h0};
    a_st = 1'b0;
    step();
    chk("unstall out", a_out, 32'hAAAA5555);
    chk("unstall cnt", 32'(a_cnt), 2);
    {b_sel, b_v} = {2'd3, 1'b1};
    step();
    chk("bad sel out", b_out, 32'hDEADBEEF);
    chk("bad sel err", 32'(b_err), 1);
    chk("bad sel cnt", 32'(b_cnt), 0);
    b_sel = 2'd1;
    step();
    chk("sel1 out", b_out, 32'h0BADF00D);
    chk("sel1 err", 32'(b_err), 0);
    chk("sel1 cnt", 32'(b_cnt), 1);
    {b_sel, b_v} = {2'd3, 1'b0};
    step();
    chk("bad sel inv err", 32'(b_err), 0);
    chk("bad sel inv out", b_out, 32'hDEADBEEF);
    {b_sel, b_v} = {2'd2, 1'b1};
    step();
    chk("sel2 out", b_out, 32'h12345678);
    chk("sel2 cnt", 32'(b_cnt), 2);
    b_sel = 2'd3;
    step();
    chk("bad sel2 err", 32'(b_err), 1);
    b_fl = 1'b1;
    step();
    chk("flush err", 32'(b_err), 0);
    chk("flush cnt", 32'(b_cnt), 2);
    {b_fl, b_v} = '0;
    {c_sel, c_v} = {2'd1, 1'b1};
    for (int i = 0; i < 20; i++) begin
      step();
      chk($sformatf("sat%0d cnt", i), 32'(c_cnt), (i + 1 > 15) ? 15 : i + 1);
    end
    chk("sat out", c_out, 32'hC0C0C0C1);
    c_clr = 1'b1;
    step();
    chk("clr vs inc", 32'(c_cnt), 0);
    c_clr = 1'b0;
    step();
    chk("after clr", 32'(c_cnt), 1);
    c_v = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async out", a_out, 0);
    chk("async valid", 32'(a_ov), 0);
    chk("async cnt", 32'(a_cnt), 0);
    chk("async c_cnt", 32'(c_cnt), 0);
    a_st = 1'b1;
    step();
    rst_n = 1'b1;
    step();
    chk("rel stall valid", 32'(a_ov), 0);
    chk("rel stall out", a_out, 0);
    a_bus = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    {a_sel, a_v, a_st} = {2'd3, 1'b1, 1'b0};
    step();
    chk("post rst out", a_out, 32'h44444444);
    chk("post rst cnt", 32'(a_cnt), 1);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule

// File: doc/fwd_operand_mux.md
# fwd_operand_mux

Parametrised, registered N-to-1 operand-forwarding multiplexer for the EX stage of the MIPS pipeline. Each cycle it selects one of NSRC WIDTH-bit sources (register file, EX/MEM, MEM/WB, immediate, …) and registers the result with a valid bit. It honours pipeline stall and flush, flags out-of-range selects, and keeps a saturating count of forwarded (non-source-0) operands for hazard profiling.

## Interface
- WIDTH, 32, data width of each source and of the output
- NSRC, 4, number of sources, 2..16, need not be a power of two
- SELW, derived = max(1, ceil(log2(NSRC))), select width; not overridable
- CNTW, 16, width of the forwarding counter
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_bus  in  NSRC*WIDTH  packed sources; source k occupies bits [k*WIDTH +: WIDTH]
- sel  in  SELW  source index
- in_valid  in  1  the current selection carries a real instruction operand
- stall  in  1  hold all registered state
- flush  in  1  kill the registered operand (bubble insert)
- cnt_clr  in  1  synchronous clear of fwd_count
- out  out  WIDTH  registered selected operand
- out_valid  out  1  out holds a live operand
- sel_err  out  1  registered flag: the captured operand had sel >= NSRC
- fwd_count  out  CNTW  saturating count of captured valid operands with 0 < sel < NSRC

## Operation
- Combinational pick: if sel < NSRC, pick source sel; otherwise pick source 0 and raise the internal error.
- Per-edge priority (highest first): reset, flush, stall, load.
- Reset (rst_n=0, asynchronous): out=0, out_valid=0, sel_err=0, fwd_count=0.
- Flush: out=0, out_valid=0, sel_err=0. Flush overrides stall in the same cycle.
- Stall (no flush): out, out_valid and sel_err hold. fwd_count does not change.
- Load (no flush, no stall):
  - out = pick.
  - out_valid = in_valid.
  - sel_err = in_valid & (sel >= NSRC).
  - The data is loaded even when in_valid=0. out is don't-care when out_valid=0, but must equal pick.
- fwd_count:
  - Increments by 1 on a load with in_valid=1 and 0 < sel < NSRC.
  - Saturates at 2^CNTW−1 and never wraps.
  - cnt_clr forces it to 0 and wins over an increment in the same cycle.
  - cnt_clr acts regardless of stall and flush.
  - Flush and stall never increment it.
- sel=0 is the non-forwarded path and is never counted.
- An erroneous sel is never counted.
- When NSRC is a power of two, sel_err is constantly 0.

## Timing
- Latency: 1 cycle. Inputs sampled at edge N appear on out/out_valid/sel_err after edge N.
- No combinational path from any input to any output.
- stall held for K cycles freezes the outputs for K edges. The first load after stall drops uses the inputs present at that edge.
- rst_n deasserted mid-stall or mid-flush: outputs stay at reset values until the first load edge.
- rst_n asserted asynchronously clears outputs immediately, without waiting for a clock edge.
- fwd_count is visible 1 cycle after the counted load.

## Test plan
- Reset release, then for sel=0..3 load in_bus sources {0x11111111, 0x22222222, 0x33333333, 0x44444444} with in_valid=1. Required: out follows 1 cycle later, out_valid=1, fwd_count ends at 3.
- Load sel=2 (0x33333333), then stall=1 for 3 cycles while sel=1 and sources change. Required: out stays 0x33333333 and fwd_count stays constant. First edge after stall drops loads source 1.
- stall=1 and flush=1 together. Required: next cycle out=0, out_valid=0, sel_err=0, no count.
- NSRC=3, sel=3, in_valid=1, source 0 = 0xDEADBEEF. Required: out=0xDEADBEEF, sel_err=1, fwd_count unchanged. Next load with sel=1 clears sel_err.
- CNTW=4, 20 valid loads with sel=1. Required: fwd_count saturates at 15. A cnt_clr coinciding with a counted load gives 0.
- Assert rst_n low mid-cycle with out_valid=1. Required: out, out_valid and fwd_count go to 0 before the next clock edge.
